// File: rtl/axi_vdma_wr_burst_sched.sv
`default_nettype none
// ============================================================================
// Module   : axi_vdma_wr_burst_sched
// Brief    : Splits a video frame (VSIZE lines of HSIZE beats, STRIDE-byte
//            line pitch) into AXI INCR burst requests for the write core.
//            Each burst is gated on the write-FIFO fill level. Only one
//            burst is outstanding at a time. The scheduler reports frame
//            completion and BRESP errors.
// Option   : `define VDMA_4K_SPLIT_EN clips bursts at 4 KB address boundaries
// Revision : 1.0 - initial release
// ============================================================================
module axi_vdma_wr_burst_sched #(
    parameter int ASIZE      = 32,
    parameter int LSIZE      = 8,
    parameter int MAX_BURST  = 64,
    parameter int BEAT_BYTES = 32,
    parameter int HSIZE_W    = 16,
    parameter int CSIZE      = 10
) (
    input  logic               axi_aclk,
    input  logic               axi_resetn,
    input  logic               frame_start,
    input  logic [ASIZE-1:0]   base_addr,
    input  logic [HSIZE_W-1:0] hsize,
    input  logic [HSIZE_W-1:0] vsize,
    input  logic [ASIZE-1:0]   stride,
    input  logic [CSIZE-1:0]   fifo_count,
    output logic               write_req,
    output logic [LSIZE-1:0]   req_len,
    output logic [ASIZE-1:0]   req_addr,
    input  logic               req_resp,
    input  logic               req_done,
    input  logic               req_err,
    output logic               frame_busy,
    output logic               frame_done,
    output logic               frame_err
);

    // Byte offset of a beat index is a shift because BEAT_BYTES is a power of two
    localparam int BB_SHIFT = $clog2(BEAT_BYTES);
    // Common width for comparing the FIFO level against a burst size
    localparam int CW = (HSIZE_W > CSIZE) ? HSIZE_W : CSIZE;
    localparam logic [HSIZE_W-1:0] MAX_BURST_C = HSIZE_W'(MAX_BURST);
    localparam logic [HSIZE_W-1:0] ONE_H       = HSIZE_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_REQ       = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_NEXT      = 3'd5,
        S_FINISH    = 3'd6
    } state_t;

    state_t             state_q;

    // Frame configuration captured on the accepted frame_start
    logic [HSIZE_W-1:0] hsize_q;
    logic [HSIZE_W-1:0] vsize_q;
    logic [ASIZE-1:0]   stride_q;
    logic [ASIZE-1:0]   base_q;

    // Walking position within the frame
    logic [ASIZE-1:0]   line_addr_q;
    logic [HSIZE_W-1:0] beat_rem_q;
    logic [HSIZE_W-1:0] line_rem_q;
    logic [HSIZE_W-1:0] burst_q;

    // Registered outputs
    logic               write_req_q;
    logic [LSIZE-1:0]   req_len_q;
    logic [ASIZE-1:0]   req_addr_q;
    logic               frame_busy_q;
    logic               frame_done_q;
    logic               frame_err_q;

    // Combinational next values
    logic [HSIZE_W-1:0] beats_done;
    logic [ASIZE-1:0]   req_addr_d;
    logic [HSIZE_W-1:0] burst_lim;
    logic [HSIZE_W-1:0] burst_d;
    logic [HSIZE_W-1:0] beat_rem_d;
    logic [HSIZE_W-1:0] line_rem_d;
    logic               fifo_ok;

    // Start address of the next burst: line start plus the beats already sent on this line
    assign beats_done = hsize_q - beat_rem_q;
    assign req_addr_d = line_addr_q + (ASIZE'(beats_done) << BB_SHIFT);

    // Burst size is bounded by the protocol limit and by what is left of the line
    assign burst_lim  = (beat_rem_q < MAX_BURST_C) ? beat_rem_q : MAX_BURST_C;

`ifdef VDMA_4K_SPLIT_EN
    logic [12:0]        room_bytes;
    logic [HSIZE_W-1:0] room_beats;

    // Bytes left before the next 4 KB page. An aligned address yields a full page.
    assign room_bytes = 13'h1000 - {1'b0, req_addr_d[11:0]};
    assign room_beats = HSIZE_W'(room_bytes >> BB_SHIFT);
    assign burst_d    = (room_beats < burst_lim) ? room_beats : burst_lim;
`else
    // Bursts may cross a 4 KB page; the caller keeps addresses legal
    assign burst_d    = burst_lim;
`endif

    // Issue only once the FIFO already holds the whole burst
    assign fifo_ok    = (CW'(fifo_count) >= CW'(burst_d));

    assign beat_rem_d = beat_rem_q - burst_q;
    assign line_rem_d = line_rem_q - ONE_H;

    // Frame walker FSM; all outputs are registered here
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q      <= S_IDLE;
            hsize_q      <= '0;
            vsize_q      <= '0;
            stride_q     <= '0;
            base_q       <= '0;
            line_addr_q  <= '0;
            beat_rem_q   <= '0;
            line_rem_q   <= '0;
            burst_q      <= '0;
            write_req_q  <= 1'b0;
            req_len_q    <= '0;
            req_addr_q   <= '0;
            frame_busy_q <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            // frame_done is a single-cycle pulse raised on entry to FINISH
            frame_done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (frame_start) begin
                        hsize_q      <= hsize;
                        vsize_q      <= vsize;
                        stride_q     <= stride;
                        base_q       <= base_addr;
                        frame_err_q  <= 1'b0;
                        frame_busy_q <= 1'b1;
                        state_q      <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if ((hsize_q == '0) || (vsize_q == '0)) begin
                        frame_done_q <= 1'b1;
                        state_q      <= S_FINISH;
                    end else begin
                        line_addr_q  <= base_q;
                        beat_rem_q   <= hsize_q;
                        line_rem_q   <= vsize_q;
                        state_q      <= S_WAIT_DATA;
                    end
                end

                S_WAIT_DATA: begin
                    burst_q <= burst_d;
                    if (fifo_ok) begin
                        write_req_q <= 1'b1;
                        req_len_q   <= LSIZE'(burst_d - ONE_H);
                        req_addr_q  <= req_addr_d;
                        state_q     <= S_REQ;
                    end
                end

                S_REQ: begin
                    // req_len/req_addr hold until the core takes the request
                    if (req_resp) begin
                        write_req_q <= 1'b0;
                        state_q     <= S_WAIT_DONE;
                    end
                end

                S_WAIT_DONE: begin
                    if (req_done) begin
                        if (req_err) begin
                            frame_err_q  <= 1'b1;
                            frame_done_q <= 1'b1;
                            state_q      <= S_FINISH;
                        end else begin
                            state_q      <= S_NEXT;
                        end
                    end
                end

                S_NEXT: begin
                    if (beat_rem_d == '0) begin
                        // Line finished: step to the next line start
                        line_rem_q  <= line_rem_d;
                        line_addr_q <= line_addr_q + stride_q;
                        beat_rem_q  <= hsize_q;
                        if (line_rem_d == '0) begin
                            frame_done_q <= 1'b1;
                            state_q      <= S_FINISH;
                        end else begin
                            state_q      <= S_WAIT_DATA;
                        end
                    end else begin
                        beat_rem_q <= beat_rem_d;
                        state_q    <= S_WAIT_DATA;
                    end
                end

                S_FINISH: begin
                    frame_busy_q <= 1'b0;
                    state_q      <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign write_req  = write_req_q;
    assign req_len    = req_len_q;
    assign req_addr   = req_addr_q;
    assign frame_busy = frame_busy_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_vdma_wr_burst_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_vdma_wr_burst_sched
// Brief    : Scoreboard bench for axi_vdma_wr_burst_sched. Stimulus pushes
//            expected bursts and frame ends. A core-model/monitor process
//            pops the queue on each request and each frame_done.
// Option   : honours `define VDMA_4K_SPLIT_EN for the 4 KB split vector
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_vdma_wr_burst_sched;

    localparam int ASIZE      = 32;
    localparam int LSIZE      = 8;
    localparam int MAX_BURST  = 64;
    localparam int BEAT_BYTES = 32;
    localparam int HSIZE_W    = 16;
    localparam int CSIZE      = 10;

    logic               axi_aclk;
    logic               axi_resetn;
    logic               frame_start;
    logic [ASIZE-1:0]   base_addr;
    logic [HSIZE_W-1:0] hsize;
    logic [HSIZE_W-1:0] vsize;
    logic [ASIZE-1:0]   stride;
    logic [CSIZE-1:0]   fifo_count;
    logic               write_req;
    logic [LSIZE-1:0]   req_len;
    logic [ASIZE-1:0]   req_addr;
    logic               req_resp;
    logic               req_done;
    logic               req_err;
    logic               frame_busy;
    logic               frame_done;
    logic               frame_err;

    axi_vdma_wr_burst_sched #(
        .ASIZE      (ASIZE),
        .LSIZE      (LSIZE),
        .MAX_BURST  (MAX_BURST),
        .BEAT_BYTES (BEAT_BYTES),
        .HSIZE_W    (HSIZE_W),
        .CSIZE      (CSIZE)
    ) u_dut (
        .axi_aclk   (axi_aclk),
        .axi_resetn (axi_resetn),
        .frame_start(frame_start),
        .base_addr  (base_addr),
        .hsize      (hsize),
        .vsize      (vsize),
        .stride     (stride),
        .fifo_count (fifo_count),
        .write_req  (write_req),
        .req_len    (req_len),
        .req_addr   (req_addr),
        .req_resp   (req_resp),
        .req_done   (req_done),
        .req_err    (req_err),
        .frame_busy (frame_busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    initial axi_aclk = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected bursts {req_len, req_addr} and expected frame_err at each frame_done
    logic [LSIZE+ASIZE-1:0] exp_req[$];
    logic                   exp_fd[$];

    int fd_seen  = 0;
    int acc_cnt  = 0;
    int err_at   = -1;
    int done_dly = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic push_req(input logic [LSIZE-1:0] len, input logic [ASIZE-1:0] addr);
        exp_req.push_back({len, addr});
    endtask

    // Called on a negedge; returns on the following negedge with frame_start low
    task automatic start_frame(input logic [ASIZE-1:0] b, input logic [HSIZE_W-1:0] h,
                               input logic [HSIZE_W-1:0] v, input logic [ASIZE-1:0] s);
        base_addr   = b;
        hsize       = h;
        vsize       = v;
        stride      = s;
        frame_start = 1'b1;
        @(negedge axi_aclk);
        frame_start = 1'b0;
    endtask

    task automatic wait_frame(input int target);
        for (int i = 0; i < 3000 && fd_seen < target; i++) @(negedge axi_aclk);
        if (fd_seen < target) check("frame_timeout", 64'(fd_seen), 64'(target));
        repeat (3) @(negedge axi_aclk);
    endtask

    // Write-core model plus output monitor; all sampling on the falling edge
    initial begin : core_monitor
        logic                   in_flight;
        logic                   cur_err;
        int                     dcnt;
        logic [LSIZE+ASIZE-1:0] e;
        logic                   efe;
        in_flight = 1'b0;
        cur_err   = 1'b0;
        dcnt      = 0;
        req_resp  = 1'b0;
        req_done  = 1'b0;
        req_err   = 1'b0;
        forever begin
            @(negedge axi_aclk);
            req_resp = 1'b0;
            req_done = 1'b0;
            req_err  = 1'b0;
            if (!axi_resetn) begin
                in_flight = 1'b0;
                dcnt      = 0;
            end else begin
                if (frame_done) begin
                    fd_seen++;
                    if (exp_fd.size() == 0) begin
                        check("unexpected_frame_done", 64'(frame_done), 64'(0));
                    end else begin
                        efe = exp_fd.pop_front();
                        check("frame_err_at_done", 64'(frame_err), 64'(efe));
                    end
                end
                if (in_flight) begin
                    if (dcnt <= 1) begin
                        req_done  = 1'b1;
                        req_err   = cur_err;
                        in_flight = 1'b0;
                    end else begin
                        dcnt--;
                    end
                end else if (write_req) begin
                    if (exp_req.size() == 0) begin
                        check("unexpected_write_req", 64'({req_len, req_addr}), 64'(0));
                    end else begin
                        e = exp_req.pop_front();
                        check("burst_len_addr", 64'({req_len, req_addr}), 64'(e));
                    end
                    req_resp  = 1'b1;
                    in_flight = 1'b1;
                    dcnt      = done_dly;
                    cur_err   = (acc_cnt == err_at);
                    acc_cnt++;
                end
            end
        end
    end

    initial begin : stimulus
        int tgt;
        int a0;
        axi_resetn  = 1'b0;
        frame_start = 1'b0;
        base_addr   = '0;
        hsize       = '0;
        vsize       = '0;
        stride      = '0;
        fifo_count  = 10'd1023;

        repeat (3) @(negedge axi_aclk);
        check("reset_outputs",
              64'({write_req, req_len, req_addr, frame_busy, frame_done, frame_err}), 64'(0));
        axi_resetn = 1'b1;
        repeat (2) @(negedge axi_aclk);

        // Two lines of 128 beats: two 64-beat bursts per line
        push_req(8'd63, 32'h1000);
        push_req(8'd63, 32'h1800);
        push_req(8'd63, 32'h3000);
        push_req(8'd63, 32'h3800);
        exp_fd.push_back(1'b0);
        tgt = fd_seen + 1;
        start_frame(32'h1000, 16'd128, 16'd2, 32'h2000);
        check("busy_after_start", 64'(frame_busy), 64'(1));
        @(negedge axi_aclk);
        check("no_req_at_2_cycles", 64'(write_req), 64'(0));
        @(negedge axi_aclk);
        check("req_at_3_cycles", 64'(write_req), 64'(1));
        wait_frame(tgt);
        check("busy_after_frame", 64'(frame_busy), 64'(0));

        // Partial trailing burst
        push_req(8'd63, 32'h0);
        push_req(8'd35, 32'h800);
        exp_fd.push_back(1'b0);
        tgt = fd_seen + 1;
        start_frame(32'h0, 16'd100, 16'd1, 32'h0);
        wait_frame(tgt);

        // FIFO gating: hold below the burst size, then release
        fifo_count = 10'd40;
        tgt = fd_seen + 1;
        start_frame(32'h4000, 16'd64, 16'd1, 32'h0);
        repeat (20) @(negedge axi_aclk);
        check("fifo_hold_no_req", 64'(write_req), 64'(0));
        push_req(8'd63, 32'h4000);
        exp_fd.push_back(1'b0);
        fifo_count = 10'd64;
        @(negedge axi_aclk);
        check("fifo_release_req", 64'(write_req), 64'(1));
        wait_frame(tgt);
        fifo_count = 10'd1023;

        // Error on the second burst aborts the frame
        err_at = acc_cnt + 1;
        push_req(8'd63, 32'h0);
        push_req(8'd63, 32'h800);
        exp_fd.push_back(1'b1);
        tgt = fd_seen + 1;
        start_frame(32'h0, 16'd128, 16'd2, 32'h2000);
        wait_frame(tgt);
        err_at = -1;
        repeat (10) @(negedge axi_aclk);
        check("err_sticky", 64'(frame_err), 64'(1));

        // Zero-length frame clears the error and finishes two cycles after the start
        exp_fd.push_back(1'b0);
        tgt = fd_seen + 1;
        start_frame(32'h0, 16'd0, 16'd1, 32'h0);
        check("err_cleared", 64'(frame_err), 64'(0));
        check("zero_len_no_early_done", 64'(frame_done), 64'(0));
        @(negedge axi_aclk);
        check("zero_len_done_2cyc", 64'(frame_done), 64'(1));
        wait_frame(tgt);

        // frame_start while busy is ignored
        push_req(8'd63, 32'h8000);
        exp_fd.push_back(1'b0);
        tgt = fd_seen + 1;
        start_frame(32'h8000, 16'd64, 16'd1, 32'h0);
        start_frame(32'h9000, 16'd64, 16'd1, 32'h0);
        wait_frame(tgt);
        check("busy_restart_ignored_frames", 64'(fd_seen), 64'(tgt));

        // 4 KB boundary vector
`ifdef VDMA_4K_SPLIT_EN
        push_req(8'd3, 32'hF80);
        push_req(8'd59, 32'h1000);
`else
        push_req(8'd63, 32'hF80);
`endif
        exp_fd.push_back(1'b0);
        tgt = fd_seen + 1;
        start_frame(32'hF80, 16'd64, 16'd1, 32'h0);
        wait_frame(tgt);

        // Reset while waiting for req_done: outputs clear, no frame_done pulse
        done_dly = 20;
        push_req(8'd63, 32'hA000);
        a0 = acc_cnt;
        start_frame(32'hA000, 16'd64, 16'd1, 32'h0);
        for (int i = 0; i < 100 && acc_cnt == a0; i++) @(negedge axi_aclk);
        check("reset_test_accepted", 64'(acc_cnt), 64'(a0 + 1));
        repeat (3) @(negedge axi_aclk);
        check("busy_before_reset", 64'(frame_busy), 64'(1));
        axi_resetn = 1'b0;
        #1;
        check("midframe_reset_outputs",
              64'({write_req, req_len, req_addr, frame_busy, frame_done, frame_err}), 64'(0));
        repeat (3) @(negedge axi_aclk);
        axi_resetn = 1'b1;
        done_dly   = 1;
        a0 = fd_seen;
        repeat (30) @(negedge axi_aclk);
        check("no_done_after_reset", 64'(fd_seen), 64'(a0));
        check("idle_after_reset", 64'({write_req, frame_busy}), 64'(0));

        check("req_queue_empty", 64'(exp_req.size()), 64'(0));
        check("fd_queue_empty", 64'(exp_fd.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
